// File: rtl/cordic_seq_ctrl.sv
// Sequencer for the CORDIC process datapath: one load cycle plus N_ITER micro-rotations.
// Vectoring records the per-iteration directions; rotation replays them on a new operand pair.
module cordic_seq_ctrl #(
    parameter int unsigned WIDTH_SHIFT_BIT = 4,
    parameter int unsigned N_ITER          = 15
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       start_i,
    input  logic                       mode_i,
    input  logic                       pre_sign_i,
    input  logic                       stall_i,
    input  logic                       sign_out_i,
    output logic                       ce_o,
    output logic                       sel_o,
    output logic [WIDTH_SHIFT_BIT-1:0] shift_bit_o,
    output logic                       sign_in_o,
    output logic                       sign_rotation_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       dir_valid_o,
    output logic [N_ITER:0]            dir_out_o,
    output logic                       err_o
);
    localparam logic [WIDTH_SHIFT_BIT-1:0] PenultIdx = WIDTH_SHIFT_BIT'(N_ITER - 2);

    typedef enum logic [1:0] {StIdle, StLoad, StIter, StFinal} state_e;

    state_e                     state_q, state_d;
    logic [WIDTH_SHIFT_BIT-1:0] cnt_q, cnt_d;
    logic                       mode_q, mode_d;
    logic                       pre_q, pre_d;
    logic [N_ITER-1:0]          dir_q, dir_d;
    logic                       dir_valid_q, dir_valid_d;
    logic                       err_q, err_d;
    logic                       accept, reject, advance, dir_bit;

    assign accept  = (state_q == StIdle) && start_i && (!mode_i || dir_valid_q);
    assign reject  = (state_q == StIdle) && start_i && mode_i && !dir_valid_q;
    assign advance = (state_q == StIter) && !stall_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StLoad;
            StLoad:  if (!stall_i) state_d = StIter;
            StIter:  if (advance && (cnt_q == PenultIdx)) state_d = StFinal;
            StFinal: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Stored direction for the current iteration, used when replaying.
    always_comb begin
        dir_bit = 1'b0;
        for (int unsigned k = 0; k < N_ITER; k++) begin
            if (cnt_q == WIDTH_SHIFT_BIT'(k)) dir_bit = dir_q[k];
        end
    end

    always_comb begin
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        pre_d       = pre_q;
        dir_d       = dir_q;
        dir_valid_d = dir_valid_q;
        err_d       = reject;
        if (accept) begin
            cnt_d  = '0;
            mode_d = mode_i;
            // A new vectoring run invalidates the old set until it completes.
            if (!mode_i) begin
                pre_d       = pre_sign_i;
                dir_valid_d = 1'b0;
            end
        end
        if (advance) cnt_d = cnt_q + 1'b1;
        if (!mode_q && (advance || (state_q == StFinal))) begin
            for (int unsigned k = 0; k < N_ITER; k++) begin
                if (cnt_q == WIDTH_SHIFT_BIT'(k)) dir_d[k] = sign_out_i;
            end
        end
        if (!mode_q && (state_q == StFinal)) dir_valid_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q       <= '0;
            mode_q      <= 1'b0;
            pre_q       <= 1'b0;
            dir_q       <= '0;
            dir_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            pre_q       <= pre_d;
            dir_q       <= dir_d;
            dir_valid_q <= dir_valid_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        ce_o        = 1'b0;
        sel_o       = 1'b0;
        shift_bit_o = '0;
        sign_in_o   = 1'b0;
        busy_o      = 1'b1;
        done_o      = 1'b0;
        unique case (state_q)
            StIdle: busy_o = 1'b0;
            StLoad: ce_o = !stall_i;
            StIter: begin
                ce_o        = !stall_i;
                sel_o       = 1'b1;
                shift_bit_o = cnt_q;
                sign_in_o   = mode_q ? dir_bit : sign_out_i;
            end
            StFinal: begin
                sel_o       = 1'b1;
                shift_bit_o = cnt_q;
                sign_in_o   = mode_q ? dir_bit : sign_out_i;
                done_o      = 1'b1;
            end
            default: busy_o = 1'b0;
        endcase
    end

    assign sign_rotation_o = busy_o & pre_q;
    assign dir_valid_o     = dir_valid_q;
    assign dir_out_o       = {pre_q, dir_q};
    assign err_o           = err_q;

endmodule

// File: tb/tb_cordic_seq_ctrl.sv
// Bench for cordic_seq_ctrl: an operation-position model checked every cycle,
// plus directed runs with hand-computed latencies and direction sets.
module tb_cordic_seq_ctrl;
    localparam int N = 15;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0, mode = 1'b0, pre_sign = 1'b0, stall = 1'b0, sign_out = 1'b0;
    logic         ce, sel, sign_in, sign_rotation, busy, done, dir_valid, err;
    logic [W-1:0] shift_bit;
    logic [N:0]   dir_out;

    always #5 clk = ~clk;

    cordic_seq_ctrl #(.WIDTH_SHIFT_BIT(W), .N_ITER(N)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .start_i         (start),
        .mode_i          (mode),
        .pre_sign_i      (pre_sign),
        .stall_i         (stall),
        .sign_out_i      (sign_out),
        .ce_o            (ce),
        .sel_o           (sel),
        .shift_bit_o     (shift_bit),
        .sign_in_o       (sign_in),
        .sign_rotation_o (sign_rotation),
        .busy_o          (busy),
        .done_o          (done),
        .dir_valid_o     (dir_valid),
        .dir_out_o       (dir_out),
        .err_o           (err)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pos = -1 idle, 0 load, 1..N-1 iteration pos-1, N final iteration.
    int         pos = -1;
    bit         m_mode, m_pre, m_valid, m_err;
    bit [N-1:0] m_dir;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos <= -1; m_mode <= 0; m_pre <= 0; m_valid <= 0; m_err <= 0; m_dir <= '0;
        end else begin
            m_err <= 0;
            if (pos < 0) begin
                if (start && (!mode || m_valid)) begin
                    pos <= 0;
                    m_mode <= mode;
                    if (!mode) begin m_pre <= pre_sign; m_valid <= 0; end
                end else if (start) begin
                    m_err <= 1;
                end
            end else if (pos == N) begin
                pos <= -1;
                if (!m_mode) begin m_dir[N-1] <= sign_out; m_valid <= 1; end
            end else if (!stall) begin
                if (pos >= 1 && !m_mode) m_dir[pos-1] <= sign_out;
                pos <= pos + 1;
            end
        end
    end

    bit chk_en = 0;
    always @(negedge clk) begin
        bit e_si;
        bit e_busy;
        if (chk_en) begin
            e_busy = (pos >= 0);
            e_si = 0;
            if (pos >= 1) e_si = m_mode ? m_dir[pos-1] : sign_out;
            check("busy", 32'(busy), 32'(e_busy));
            check("done", 32'(done), 32'(pos == N));
            check("ce", 32'(ce), 32'(pos >= 0 && pos < N && !stall));
            check("sel", 32'(sel), 32'(pos >= 1));
            check("shift_bit", 32'(shift_bit), (pos >= 1) ? 32'(pos - 1) : 32'd0);
            check("sign_in", 32'(sign_in), 32'(e_si));
            check("sign_rotation", 32'(sign_rotation), 32'(e_busy && m_pre));
            check("dir_valid", 32'(dir_valid), 32'(m_valid));
            check("dir_out", 32'(dir_out), 32'({m_pre, m_dir}));
            check("err", 32'(err), 32'(m_err));
        end
    end

    task automatic run_op(input bit md, input bit ps, input bit [N-1:0] pat, input int st_at,
                          input int st_len, output int lat, output bit [N-1:0] seen,
                          output bit srot);
        int stalled = 0;
        lat = -1; seen = '0; srot = 0;
        @(posedge clk); #2;
        start = 1; mode = md; pre_sign = ps; stall = 0;
        for (int c = 1; c <= 80; c++) begin
            @(posedge clk); #2;
            start = 0;
            stall = 0;
            if (pos == st_at + 1 && stalled < st_len) begin stall = 1; stalled++; end
            sign_out = (!md && pos >= 1) ? pat[pos-1] : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (sel) seen[shift_bit] = sign_in;
            if (busy) srot = sign_rotation;
            if (done) begin lat = c; break; end
        end
        stall = 0;
    endtask

    initial begin
        int         lat, t1, t2;
        bit [N-1:0] seen, pa, pb, pc;
        bit         srot;
        logic [N:0] exp_dir;
        pa = 15'h5A3C; pb = 15'h2B61; pc = 15'h1F0E;
        t1 = -1; t2 = -1;

        #3 rst_n = 0; chk_en = 1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1;
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_dir_out", 32'(dir_out), 0);
        check("rst_dir_valid", 32'(dir_valid), 0);

        // Rotation with nothing stored: err for one cycle, never busy.
        @(posedge clk); #2; start = 1; mode = 1;
        @(posedge clk); #2; start = 0;
        @(negedge clk);
        check("err_pulse", 32'(err), 1);
        check("err_busy", 32'(busy), 0);
        @(negedge clk);
        check("err_clear", 32'(err), 0);

        // Vectoring run, pattern A, pre_sign 1.
        run_op(0, 1, pa, -10, 0, lat, seen, srot);
        check("vec_latency", 32'(lat), 16);
        check("vec_final_shift", 32'(shift_bit), 14);
        check("vec_final_ce", 32'(ce), 0);
        check("vec_srot", 32'(srot), 1);
        @(negedge clk);
        exp_dir = {1'b1, pa};
        check("vec_dir_out", 32'(dir_out), 32'(exp_dir));
        check("vec_dir_valid", 32'(dir_valid), 1);

        // Rotation replay: random sign_out must not leak into sign_in.
        run_op(1, 0, '0, -10, 0, lat, seen, srot);
        check("rot_latency", 32'(lat), 16);
        check("rot_replay", 32'(seen), 32'(pa));
        check("rot_srot", 32'(srot), 1);
        @(negedge clk);
        check("rot_dir_kept", 32'(dir_out), 32'(exp_dir));

        // Vectoring with a 3-cycle stall at i = 5.
        run_op(0, 0, pb, 5, 3, lat, seen, srot);
        check("stall_latency", 32'(lat), 19);
        @(negedge clk);
        exp_dir = {1'b0, pb};
        check("stall_dir_out", 32'(dir_out), 32'(exp_dir));
        check("stall_dir_valid", 32'(dir_valid), 1);

        // stall during the final cycle is ignored.
        run_op(0, 1, pc, N - 1, 2, lat, seen, srot);
        check("final_stall_latency", 32'(lat), 16);

        // Reset at i = 7 of a vectoring run.
        @(posedge clk); #2; start = 1; mode = 0; pre_sign = 1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #2;
            start = 0;
            sign_out = 1'($urandom_range(0, 1));
            if (pos == 8) break;
        end
        check("reach_i7", 32'(pos), 8);
        rst_n = 0;
        #1;
        check("abort_busy", 32'(busy), 0);
        check("abort_dir_valid", 32'(dir_valid), 0);
        check("abort_dir_out", 32'(dir_out), 0);
        @(posedge clk); #2; rst_n = 1;
        @(posedge clk); #2; start = 1; mode = 1;
        @(posedge clk); #2; start = 0;
        @(negedge clk);
        check("abort_err", 32'(err), 1);
        check("abort_err_busy", 32'(busy), 0);

        // start held high: back-to-back vectoring runs.
        @(posedge clk); #2; start = 1; mode = 0; pre_sign = 0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk); #2;
            sign_out = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (done) begin
                if (t1 < 0) t1 = c;
                else begin t2 = c; break; end
            end
        end
        start = 0;
        check("b2b_first_done", 32'(t1), 15);
        check("b2b_gap", 32'(t2 - t1), 17);
        repeat (3) @(negedge clk);
        check("b2b_idle", 32'(busy), 0);

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end
endmodule
